// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions.
// Holds the opcode and function constants, the JumpType encoding, the
// decode-stage FSM states, the IF/ID latch layout and the NOP pattern that
// fills the latch during reset and trap drain.
package dlx_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_NOP     = 6'h15;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_BFPT    = 6'h06;
    localparam logic [5:0] OP_BFPF    = 6'h07;
    localparam logic [5:0] OP_RFE     = 6'h10;
    localparam logic [5:0] OP_TRAP    = 6'h11;
    localparam logic [5:0] OP_JR      = 6'h12;
    localparam logic [5:0] OP_JALR    = 6'h13;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW_LAST = 6'h25;
    localparam logic [5:0] OP_LF      = 6'h26;
    localparam logic [5:0] OP_LD      = 6'h27;

    typedef enum logic [1:0] {
        JT_SEQ    = 2'b00,
        JT_COND   = 2'b01,
        JT_UNCOND = 2'b10,
        JT_REG    = 2'b11
    } jump_type_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_DRAIN    = 2'b01,
        ST_REDIRECT = 2'b10
    } stage_state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  func;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] pc4;
    } if_id_t;

    localparam if_id_t IF_ID_NOP = '{
        opcode: OP_SPECIAL,
        func:   FN_NOP,
        rs1:    5'd0,
        rs2:    5'd0,
        rd:     5'd0,
        imm:    16'd0,
        pc4:    32'd0
    };

    // Integer loads write a GPR; their destination feeds the hazard unit.
    function automatic logic is_gpr_load(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_LW_LAST);
    endfunction

    // Floating-point loads write an FPR; bit 5 of DecodeRd marks the FP file.
    function automatic logic is_fpr_load(input logic [5:0] op);
        return (op == OP_LF) || (op == OP_LD);
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational control decode of the latched instruction.
// Ports:
//   opcode        latched opcode
//   rd            latched destination field
//   jump_type     sequential / conditional / unconditional / register target
//   branch_cond   take-if-true flag for conditional branches
//   cond_src      0 = GPR zero test, 1 = FPSR bit
//   jump_from_iar register target comes from IAR (RFE) instead of the GPR
//   decode_rd     load destination for hazard detection, 0 when not a load
module decode_ctrl
    import dlx_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rd,
    output jump_type_t  jump_type,
    output logic        branch_cond,
    output logic        cond_src,
    output logic        jump_from_iar,
    output logic [5:0]  decode_rd
);

    always_comb begin
        jump_type     = JT_SEQ;
        branch_cond   = 1'b0;
        cond_src      = 1'b0;
        jump_from_iar = 1'b0;
        case (opcode)
            OP_BEQZ: begin jump_type = JT_COND; end
            OP_BNEZ: begin jump_type = JT_COND; branch_cond = 1'b1; end
            OP_BFPT: begin jump_type = JT_COND; cond_src = 1'b1; branch_cond = 1'b1; end
            OP_BFPF: begin jump_type = JT_COND; cond_src = 1'b1; end
            OP_J, OP_JAL:   jump_type = JT_UNCOND;
            OP_JR, OP_JALR: jump_type = JT_REG;
            OP_RFE: begin jump_type = JT_REG; jump_from_iar = 1'b1; end
            default: ;
        endcase
    end

    // r0 is never a hazard source, so non-loads report destination 0.
    always_comb begin
        decode_rd = 6'h00;
        if (is_gpr_load(opcode)) begin
            decode_rd = {1'b0, rd};
        end else if (is_fpr_load(opcode)) begin
            decode_rd = {1'b1, rd};
        end
    end

endmodule

// File: rtl/decode_stage.sv
// DLX instruction decode stage: IF/ID latch, control decode, FPSR bit, IAR
// and the TRAP sequencer.
// A TRAP in the latch saves its PC+4 into IAR and its immediate, then the
// latch is filled with NOPs for TrapDrain cycles, followed by one REDIRECT
// cycle that jumps to {14'b0, imm, 2'b00}.
// Ports:
//   clk, reset (sync, active low), stall (freeze everything except FPSR)
//   OpCode..PCPlusFour   fetch fields
//   RegData1             GPR read of latched Rs1
//   FpsrWrEn/FpsrWrData  FP compare result from writeback
//   JumpType, BranchCond, CondSrc, BranchResult, FPSR, JumpReg, IAR,
//   DecodeRd, DecodePCPlusFour, Id*   decode results to fetch/execute
//   state_dbg            current sequencer state (stage_state_t)
// Handshake: no valid/ready; every non-stalled cycle advances the stage and
// stall=1 holds the latch, sequencer and counter.
module decode_stage
    import dlx_pkg::*;
#(
    parameter int TrapDrain = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Function,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    input  logic [4:0]  Rd,
    input  logic [15:0] Immediate,
    input  logic [31:0] PCPlusFour,
    input  logic [31:0] RegData1,
    input  logic        FpsrWrEn,
    input  logic        FpsrWrData,
    output logic [1:0]  JumpType,
    output logic        BranchCond,
    output logic        CondSrc,
    output logic        BranchResult,
    output logic [31:0] FPSR,
    output logic [31:0] JumpReg,
    output logic [31:0] IAR,
    output logic [5:0]  DecodeRd,
    output logic [31:0] DecodePCPlusFour,
    output logic [5:0]  IdOpCode,
    output logic [5:0]  IdFunction,
    output logic [4:0]  IdRs1,
    output logic [4:0]  IdRs2,
    output logic [4:0]  IdRd,
    output logic [15:0] IdImmediate,
    output logic [1:0]  state_dbg
);

    localparam int CntW = 8;

    stage_state_t    state, state_next;
    if_id_t          if_id, fetch;
    logic [CntW-1:0] drain_cnt;
    logic [15:0]     trap_imm;
    logic [31:0]     iar_q;
    logic            fpsr_bit;
    logic            trap_take;
    logic            latch_nop;
    logic            redirect;
    jump_type_t      ctrl_jt;
    logic            jump_from_iar;

    assign fetch = '{opcode: OpCode, func: Function, rs1: Rs1, rs2: Rs2,
                     rd: Rd, imm: Immediate, pc4: PCPlusFour};

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_RUN;
        else        state <= state_next;
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (!stall && if_id.opcode == OP_TRAP)
                    state_next = (TrapDrain == 0) ? ST_REDIRECT : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!stall && drain_cnt == CntW'(1)) state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (!stall) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // FSM outputs. The latch loads NOPs on every edge that does not land in
    // RUN, so drain and redirect cycles carry no live instruction.
    always_comb begin
        trap_take = (state == ST_RUN) && !stall && (if_id.opcode == OP_TRAP);
        latch_nop = (state_next != ST_RUN);
        redirect  = (state == ST_REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_id     <= IF_ID_NOP;
            drain_cnt <= '0;
            trap_imm  <= '0;
            iar_q     <= '0;
            fpsr_bit  <= 1'b0;
        end else begin
            if (FpsrWrEn) fpsr_bit <= FpsrWrData;
            if (!stall) if_id <= latch_nop ? IF_ID_NOP : fetch;
            if (trap_take) begin
                iar_q     <= if_id.pc4;
                trap_imm  <= if_id.imm;
                drain_cnt <= CntW'(TrapDrain);
            end else if (state == ST_DRAIN && !stall) begin
                drain_cnt <= drain_cnt - CntW'(1);
            end
        end
    end

    decode_ctrl u_ctrl (
        .opcode        (if_id.opcode),
        .rd            (if_id.rd),
        .jump_type     (ctrl_jt),
        .branch_cond   (BranchCond),
        .cond_src      (CondSrc),
        .jump_from_iar (jump_from_iar),
        .decode_rd     (DecodeRd)
    );

    always_comb begin
        JumpType = redirect ? JT_REG : ctrl_jt;
        if (redirect)           JumpReg = {14'b0, trap_imm, 2'b00};
        else if (jump_from_iar) JumpReg = iar_q;
        else                    JumpReg = RegData1;
    end

    assign BranchResult     = (RegData1 == 32'd0);
    assign FPSR             = {31'b0, fpsr_bit};
    assign IAR              = iar_q;
    assign DecodePCPlusFour = if_id.pc4;
    assign IdOpCode         = if_id.opcode;
    assign IdFunction       = if_id.func;
    assign IdRs1            = if_id.rs1;
    assign IdRs2            = if_id.rs2;
    assign IdRd             = if_id.rd;
    assign IdImmediate      = if_id.imm;
    assign state_dbg        = state;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: TrapDrain, default 3, number of NOP cycles issued after TRAP before redirect.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-004 Port: stall  in  1  global stall; hold all state.
REQ-005 Ports: OpCode, Function  in  6 each  from fetch (already NOP 0x00/0x15 when fetch bubbles).
REQ-006 Ports: Rs1, Rs2, Rd  in  5 each; Immediate  in  16; PCPlusFour  in  32  fetch fields.
REQ-007 Port: RegData1  in  32  GPR read of latched Rs1 (combinational, from register file).
REQ-008 Ports: FpsrWrEn  in  1, FpsrWrData  in  1  FP-compare result from writeback.
REQ-009 Port: JumpType  out  2  00 sequential, 01 conditional PC-relative, 10 unconditional PC-relative, 11 register target.
REQ-010 Ports: BranchCond, CondSrc, BranchResult  out  1 each  take-if-true flag, 0=GPR/1=FPSR source, RegData1==0.
REQ-011 Ports: FPSR, JumpReg, IAR  out  32 each  status, register target, interrupt address.
REQ-012 Ports: DecodeRd  out  6; DecodePCPlusFour  out  32  load destination and PC+4 of latched instruction.
REQ-013 Ports: IdOpCode, IdFunction out 6; IdRs1, IdRs2, IdRd out 5; IdImmediate out 16  latched fields to execute.

Function
REQ-014 IF/ID latch SHALL capture all fetch fields each cycle when stall=0 and FSM=RUN; hold when stall=1.
REQ-015 Decode SHALL be purely from latched fields; outputs valid same cycle as latch contents.
REQ-016 BEQZ 0x04/BNEZ 0x05: JumpType=01, CondSrc=0, BranchCond=0/1 respectively.
REQ-017 BFPT 0x06/BFPF 0x07: JumpType=01, CondSrc=1, BranchCond=1/0 respectively.
REQ-018 J 0x02, JAL 0x03: JumpType=10; JR 0x12, JALR 0x13: JumpType=11, JumpReg=RegData1.
REQ-019 RFE 0x10: JumpType=11, JumpReg=IAR; all other opcodes JumpType=00, BranchCond=CondSrc=0.
REQ-020 BranchResult SHALL equal (RegData1==0) always; FPSR output = {31'b0, fpsr_bit}.
REQ-021 DecodeRd = {0,Rd} for opcodes 0x20-0x25, {1,Rd} for 0x26/0x27, else 6'h00 (r0 never hazards).
REQ-022 DecodePCPlusFour SHALL equal latched PCPlusFour.
REQ-023 fpsr_bit SHALL load FpsrWrData on FpsrWrEn, regardless of stall.
REQ-024 FSM states RUN, DRAIN, REDIRECT.
REQ-025 RUN->DRAIN when latched opcode = TRAP 0x11 and stall=0; IAR <= latched PCPlusFour, counter <= TrapDrain.
REQ-026 DRAIN: latch SHALL present NOP (0x00/0x15, others 0), JumpType=00; counter decrements per non-stalled cycle; at 1 -> REDIRECT.
REQ-027 REDIRECT (one cycle): JumpType=11, JumpReg={14'b0, trap Immediate, 2'b00}, fetch fields captured normally; next RUN.
REQ-028 Trap Immediate SHALL be saved in DRAIN entry; stall freezes FSM, counter and outputs.
REQ-029 TrapDrain=0 SHALL go RUN->REDIRECT directly.
REQ-030 TRAP in latch while in DRAIN impossible (NOPs); RFE while in RUN uses current IAR.

Reset
REQ-031 On clk edge with reset=0: latch = NOP (OpCode 0x00, Function 0x15, fields 0, PCPlusFour 0), FSM=RUN, counter=0.
REQ-032 Reset SHALL clear fpsr_bit and IAR to 0; outputs thus JumpType=00, DecodeRd=0, FPSR=0, IAR=0.
REQ-033 Reset SHALL override stall, FpsrWrEn and any FSM state (abort trap mid-DRAIN).

Structure
REQ-034 Opcode/function constants, JumpType encodings and NOP pattern SHALL live in shared package dlx_pkg.
REQ-035 Combinational control decode SHALL be one sub-module decode_ctrl; latch/FSM/registers in decode_stage.

Verification
REQ-036 Latch BEQZ, RegData1=0 -> JumpType=01, CondSrc=0, BranchCond=0, BranchResult=1.
REQ-037 Latch JR, RegData1=0x00001000 -> JumpType=11, JumpReg=0x00001000; stall=1 two cycles -> outputs unchanged.
REQ-038 FpsrWrEn=1, data=1, then BFPT -> FPSR=1, CondSrc=1, BranchCond=1, JumpType=01.
REQ-039 TRAP Immediate=0x0010, PCPlusFour=0x40 -> IAR=0x40, 3 NOP cycles, then JumpType=11, JumpReg=0x40; then RFE -> JumpReg=0x40.
REQ-040 reset=0 during DRAIN -> next cycle FSM=RUN, IAR=0, JumpType=00; LW (0x23, Rd=5) -> DecodeRd=0x05; LF (0x26, Rd=5) -> 0x25.
